// File: rtl/alu_pkg.sv
// Shared constants and the issue-bundle type for the decode-to-execute issue stage.
package alu_pkg;

    localparam int XLEN_FIXED = 32;

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SLL    = 5'b00001;
    localparam logic [4:0] ALU_SLT    = 5'b00010;
    localparam logic [4:0] ALU_SLTU   = 5'b00011;
    localparam logic [4:0] ALU_XOR    = 5'b00100;
    localparam logic [4:0] ALU_SRL    = 5'b00101;
    localparam logic [4:0] ALU_OR     = 5'b00110;
    localparam logic [4:0] ALU_AND    = 5'b00111;
    localparam logic [4:0] ALU_MUL    = 5'b01000;
    localparam logic [4:0] ALU_MULH   = 5'b01001;
    localparam logic [4:0] ALU_MULHSU = 5'b01010;
    localparam logic [4:0] ALU_MULHU  = 5'b01011;
    localparam logic [4:0] ALU_DIV    = 5'b01100;
    localparam logic [4:0] ALU_DIVU   = 5'b01101;
    localparam logic [4:0] ALU_REM    = 5'b01110;
    localparam logic [4:0] ALU_REMU   = 5'b01111;
    localparam logic [4:0] ALU_SUB    = 5'b10000;
    localparam logic [4:0] ALU_SRA    = 5'b10001;
    localparam logic [4:0] ALU_FWD    = 5'b11000;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef struct packed {
        logic [4:0]            select;
        logic [XLEN_FIXED-1:0] data1;
        logic [XLEN_FIXED-1:0] data2;
        logic [4:0]            rd;
        logic                  reg_write;
        logic                  illegal;
    } issue_bundle_t;

endpackage

// File: rtl/alu_op_decode.sv
// Purely combinational decode of one RV32IM instruction into an ALU issue bundle.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0]   instr,
    input  logic [31:0]   pc,
    input  logic [31:0]   rs1_data,
    input  logic [31:0]   rs2_data,
    output issue_bundle_t bundle
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] u_imm;
    logic [31:0] shamt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign i_imm  = {{20{instr[31]}}, instr[31:20]};
    assign s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign u_imm  = {instr[31:12], 12'b0};
    assign shamt  = {27'b0, instr[24:20]};

    logic        legal;
    logic [4:0]  sel;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        rw;

    always_comb begin
        legal = 1'b1;
        sel   = ALU_ADD;
        d1    = '0;
        d2    = '0;
        rw    = 1'b1;
        case (opcode)
            OPC_OP: begin
                d1 = rs1_data;
                d2 = rs2_data;
                case (funct7)
                    7'b0000000: sel = {2'b00, funct3};
                    7'b0000001: sel = {2'b01, funct3};
                    7'b0100000: begin
                        if (funct3 == 3'b000)      sel = ALU_SUB;
                        else if (funct3 == 3'b101) sel = ALU_SRA;
                        else                       legal = 1'b0;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                d1 = rs1_data;
                if (funct3 == 3'b001) begin
                    d2  = shamt;
                    sel = ALU_SLL;
                    if (funct7 != 7'b0000000) legal = 1'b0;
                end else if (funct3 == 3'b101) begin
                    d2 = shamt;
                    if (funct7 == 7'b0000000)      sel = ALU_SRL;
                    else if (funct7 == 7'b0100000) sel = ALU_SRA;
                    else                           legal = 1'b0;
                end else begin
                    d2  = i_imm;
                    sel = {2'b00, funct3};
                end
            end
            OPC_LUI: begin
                sel = ALU_FWD;
                d2  = u_imm;
            end
            OPC_AUIPC: begin
                d1 = pc;
                d2 = u_imm;
            end
            // Jumps compute the link value; the target is handled by the branch unit.
            OPC_JAL, OPC_JALR: begin
                d1 = pc;
                d2 = 32'd4;
            end
            OPC_LOAD: begin
                d1 = rs1_data;
                d2 = i_imm;
            end
            OPC_STORE: begin
                d1 = rs1_data;
                d2 = s_imm;
                rw = 1'b0;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        bundle.rd        = instr[11:7];
        bundle.select    = legal ? sel : 5'b00000;
        bundle.data1     = legal ? d1  : 32'b0;
        bundle.data2     = legal ? d2  : 32'b0;
        bundle.reg_write = legal & rw;
        bundle.illegal   = ~legal;
    end

endmodule

// File: rtl/alu_op_issue.sv
// Issue stage: decodes accepted instructions and holds them in a two-entry skid buffer.
module alu_op_issue
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [31:0]     INSTR,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] RS1_DATA,
    input  logic [XLEN-1:0] RS2_DATA,
    input  logic            FLUSH,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [4:0]      SELECT,
    output logic [XLEN-1:0] DATA1,
    output logic [XLEN-1:0] DATA2,
    output logic [4:0]      RD,
    output logic            REG_WRITE,
    output logic            ILLEGAL
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t        state_reg;
    issue_bundle_t main_reg;
    issue_bundle_t skid_reg;
    issue_bundle_t dec_bundle;
    logic          in_ready_reg;
    logic          accept;
    logic          issue;

    alu_op_decode u_decode (
        .instr    (INSTR),
        .pc       (PC),
        .rs1_data (RS1_DATA),
        .rs2_data (RS2_DATA),
        .bundle   (dec_bundle)
    );

    assign accept = IN_VALID && in_ready_reg;
    assign issue  = (state_reg != EMPTY) && OUT_READY;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg    <= EMPTY;
            main_reg     <= '0;
            skid_reg     <= '0;
            in_ready_reg <= 1'b1;
        end else if (FLUSH) begin
            state_reg    <= EMPTY;
            main_reg     <= '0;
            skid_reg     <= '0;
            in_ready_reg <= 1'b1;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        main_reg  <= dec_bundle;
                        state_reg <= ONE;
                    end
                    in_ready_reg <= 1'b1;
                end
                ONE: begin
                    case ({accept, issue})
                        2'b10: begin
                            skid_reg     <= dec_bundle;
                            state_reg    <= FULL;
                            in_ready_reg <= 1'b0;
                        end
                        2'b01: begin
                            main_reg     <= '0;
                            state_reg    <= EMPTY;
                            in_ready_reg <= 1'b1;
                        end
                        2'b11: begin
                            main_reg     <= dec_bundle;
                            in_ready_reg <= 1'b1;
                        end
                        default: in_ready_reg <= 1'b1;
                    endcase
                end
                // in_ready_reg is low here, so only the drain path exists.
                FULL: begin
                    if (issue) begin
                        main_reg     <= skid_reg;
                        skid_reg     <= '0;
                        state_reg    <= ONE;
                        in_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg    <= EMPTY;
                    in_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_reg;
    assign OUT_VALID = (state_reg != EMPTY);
    assign SELECT    = main_reg.select;
    assign DATA1     = main_reg.data1;
    assign DATA2     = main_reg.data2;
    assign RD        = main_reg.rd;
    assign REG_WRITE = main_reg.reg_write;
    assign ILLEGAL   = main_reg.illegal;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed testbench for alu_op_issue: decode table, backpressure, flush and async reset.
module tb_alu_op_issue;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] INSTR;
    logic [31:0] PC;
    logic [31:0] RS1_DATA;
    logic [31:0] RS2_DATA;
    logic        FLUSH;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [4:0]  SELECT;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic [4:0]  RD;
    logic        REG_WRITE;
    logic        ILLEGAL;

    int n_checks = 0;
    int n_pass   = 0;

    alu_op_issue #(.XLEN(32)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .INSTR     (INSTR),
        .PC        (PC),
        .RS1_DATA  (RS1_DATA),
        .RS2_DATA  (RS2_DATA),
        .FLUSH     (FLUSH),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .SELECT    (SELECT),
        .DATA1     (DATA1),
        .DATA2     (DATA2),
        .RD        (RD),
        .REG_WRITE (REG_WRITE),
        .ILLEGAL   (ILLEGAL)
    );

    always #5 CLK = ~CLK;

    // {valid, select, data1, data2, rd, reg_write, illegal}
    logic [76:0] obs;
    assign obs = {OUT_VALID, SELECT, DATA1, DATA2, RD, REG_WRITE, ILLEGAL};

    function automatic logic [76:0] exp_b(input logic v, input logic [4:0] sel,
                                          input logic [31:0] d1, input logic [31:0] d2,
                                          input logic [4:0] rd, input logic rw, input logic ill);
        return {v, sel, d1, d2, rd, rw, ill};
    endfunction

    task automatic offer(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
        IN_VALID = 1'b1;
        INSTR    = instr;
        RS1_DATA = rs1;
        RS2_DATA = rs2;
        PC       = 32'h100;
    endtask

    task automatic test_reset;
        RESET_N = 1'b0; IN_VALID = 1'b0; INSTR = '0; PC = '0;
        RS1_DATA = '0; RS2_DATA = '0; FLUSH = 1'b0; OUT_READY = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++;
        if ({obs, IN_READY} !== {77'b0, 1'b1})
            $display("FAIL reset: got out=%h in_ready=%b, want out=0 in_ready=1", obs, IN_READY);
        else n_pass++;
        RESET_N = 1'b1;
        $display("reset: out=%h in_ready=%b", obs, IN_READY);
    endtask

    task automatic test_decode;
        logic [31:0] vi [12];
        logic [76:0] ve [12];
        vi[0]  = 32'h002081B3; ve[0]  = exp_b(1, 5'b00000, 32'd5,     32'd7,          5'd3,  1, 0); // ADD
        vi[1]  = 32'h40335293; ve[1]  = exp_b(1, 5'b10001, 32'd5,     32'd3,          5'd5,  1, 0); // SRAI
        vi[2]  = 32'h123450B7; ve[2]  = exp_b(1, 5'b11000, 32'd0,     32'h12345000,   5'd1,  1, 0); // LUI
        vi[3]  = 32'h02C5D533; ve[3]  = exp_b(1, 5'b01101, 32'd5,     32'd7,          5'd10, 1, 0); // DIVU
        vi[4]  = 32'h0020A423; ve[4]  = exp_b(1, 5'b00000, 32'd5,     32'd8,          5'd8,  0, 0); // SW
        vi[5]  = 32'hFFF00093; ve[5]  = exp_b(1, 5'b00000, 32'd5,     32'hFFFFFFFF,   5'd1,  1, 0); // ADDI -1
        vi[6]  = 32'h00001117; ve[6]  = exp_b(1, 5'b00000, 32'h100,   32'h1000,       5'd2,  1, 0); // AUIPC
        vi[7]  = 32'h000000EF; ve[7]  = exp_b(1, 5'b00000, 32'h100,   32'd4,          5'd1,  1, 0); // JAL
        vi[8]  = 32'h0000007F; ve[8]  = exp_b(1, 5'b00000, 32'd0,     32'd0,          5'd0,  0, 1); // bad opcode
        vi[9]  = 32'h402081B3; ve[9]  = exp_b(1, 5'b10000, 32'd5,     32'd7,          5'd3,  1, 0); // SUB
        vi[10] = 32'h40309093; ve[10] = exp_b(1, 5'b00000, 32'd0,     32'd0,          5'd1,  0, 1); // bad SLLI
        vi[11] = 32'h00208463; ve[11] = exp_b(1, 5'b00000, 32'd0,     32'd0,          5'd8,  0, 1); // BRANCH
        OUT_READY = 1'b1;
        // Stream back to back: each negedge checks the previous vector and offers the next.
        for (int i = 0; i <= 12; i++) begin
            @(negedge CLK);
            if (i > 0) begin
                n_checks++;
                if ({obs, IN_READY} !== {ve[i-1], 1'b1})
                    $display("FAIL decode[%0d]: got %h rdy=%b, want %h rdy=1", i-1, obs, IN_READY, ve[i-1]);
                else n_pass++;
                $display("decode[%0d] instr=%h out=%h", i-1, vi[i-1], obs);
            end
            if (i < 12) offer(vi[i], 32'd5, 32'd7);
            else IN_VALID = 1'b0;
        end
        @(negedge CLK);
        n_checks++;
        if (OUT_VALID !== 1'b0) $display("FAIL drain: got out_valid=%b, want 0", OUT_VALID);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [76:0] ea, eb, ec;
        ea = exp_b(1, 5'b00000, 32'd1, 32'h10, 5'd3, 1, 0);
        eb = exp_b(1, 5'b00000, 32'd2, 32'h10, 5'd3, 1, 0);
        ec = exp_b(1, 5'b00000, 32'd3, 32'h10, 5'd3, 1, 0);
        OUT_READY = 1'b0;
        @(negedge CLK); offer(32'h002081B3, 32'd1, 32'h10);
        @(negedge CLK);
        n_checks++;
        if ({obs, IN_READY} !== {ea, 1'b1}) $display("FAIL bp_a: got %h rdy=%b, want %h rdy=1", obs, IN_READY, ea);
        else n_pass++;
        offer(32'h002081B3, 32'd2, 32'h10);
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            n_checks++;
            if ({obs, IN_READY} !== {ea, 1'b0})
                $display("FAIL bp_stall%0d: got %h rdy=%b, want %h rdy=0", k, obs, IN_READY, ea);
            else n_pass++;
            offer(32'h002081B3, 32'd3, 32'h10);
        end
        OUT_READY = 1'b1;
        $display("backpressure: A held, release");
        @(negedge CLK);
        n_checks++;
        if ({obs, IN_READY} !== {eb, 1'b1}) $display("FAIL bp_b: got %h rdy=%b, want %h rdy=1", obs, IN_READY, eb);
        else n_pass++;
        @(negedge CLK);
        IN_VALID = 1'b0;
        n_checks++;
        if (obs !== ec) $display("FAIL bp_c: got %h, want %h", obs, ec);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if (OUT_VALID !== 1'b0) $display("FAIL bp_drain: got out_valid=%b, want 0", OUT_VALID);
        else n_pass++;
        $display("backpressure: A,B,C issued in order");
    endtask

    task automatic test_flush;
        OUT_READY = 1'b0;
        @(negedge CLK); offer(32'h002081B3, 32'd11, 32'd1);
        @(negedge CLK); offer(32'h002081B3, 32'd12, 32'd1);
        @(negedge CLK); offer(32'h002081B3, 32'd13, 32'd1); FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0; IN_VALID = 1'b0;
        n_checks++;
        if ({obs, IN_READY} !== {77'b0, 1'b1}) $display("FAIL flush_full: got %h rdy=%b, want 0 rdy=1", obs, IN_READY);
        else n_pass++;
        // Flush in ONE with a real same-cycle accept: that bundle must be dropped too.
        offer(32'h002081B3, 32'd21, 32'd1);
        @(negedge CLK); offer(32'h002081B3, 32'd22, 32'd1); FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        n_checks++;
        if ({obs, IN_READY} !== {77'b0, 1'b1}) $display("FAIL flush_one: got %h rdy=%b, want 0 rdy=1", obs, IN_READY);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            n_checks++;
            if (OUT_VALID !== 1'b0) $display("FAIL flush_quiet%0d: got out_valid=%b, want 0", k, OUT_VALID);
            else n_pass++;
        end
        $display("flush: nothing issued");
    endtask

    task automatic test_reset_midstall;
        logic [76:0] ef;
        ef = exp_b(1, 5'b00000, 32'd40, 32'd2, 5'd3, 1, 0);
        OUT_READY = 1'b0;
        @(negedge CLK); offer(32'h002081B3, 32'd31, 32'd1);
        @(negedge CLK); offer(32'h002081B3, 32'd32, 32'd1);
        @(negedge CLK); IN_VALID = 1'b0;
        n_checks++;
        if (IN_READY !== 1'b0) $display("FAIL rst_full: got in_ready=%b, want 0", IN_READY);
        else n_pass++;
        #2 RESET_N = 1'b0;
        #1;
        n_checks++;
        if ({obs, IN_READY} !== {77'b0, 1'b1}) $display("FAIL rst_async: got %h rdy=%b, want 0 rdy=1", obs, IN_READY);
        else n_pass++;
        @(negedge CLK);
        RESET_N = 1'b1; OUT_READY = 1'b1;
        offer(32'h002081B3, 32'd40, 32'd2);
        @(negedge CLK);
        IN_VALID = 1'b0;
        n_checks++;
        if (obs !== ef) $display("FAIL rst_recover: got %h, want %h", obs, ef);
        else n_pass++;
        $display("reset mid-stall: recovered out=%h", obs);
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_reset_midstall();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
